serial_adder: RTL and testbench

Parametrised bit-serial adder/subtractor that extends the team's 1-bit full adder to WIDTH-bit operands. The full adder is reused across WIDTH clock cycles, and a single carry flip-flop holds the carry between bits. The block sits as a small arithmetic unit behind a start/done handshake and is the first clocked arithmetic element in the CPU datapath work. Its result is the same as a combinational adder, but with WIDTH cycles of latency and one full-adder's worth of logic.

---
 rtl/serial_adder.sv | 98 +++++++++
 tb/tb_serial_adder.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full adder reused over WIDTH cycles with a
// single carry flip-flop; start/done handshake, results registered and held.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             sub_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o,
    output logic             ovf_o
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] res_d;
    logic             carry_q;
    logic             carry_d;
    logic [CW-1:0]    cnt_q;
    logic             fa_s;
    logic             last_bit;

    assign fa_s     = a_q[0] ^ b_q[0] ^ carry_q;
    assign carry_d  = (a_q[0] & b_q[0]) | (carry_q & (a_q[0] ^ b_q[0]));
    assign last_bit = (cnt_q == CW'(WIDTH - 1));

    // Result bits enter at the MSB so after WIDTH shifts bit 0 sits at the LSB.
    generate
        if (WIDTH == 1) begin : g_res_w1
            assign res_d = fa_s;
        end else begin : g_res_wn
            assign res_d = {fa_s, res_q[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            busy_o  <= 1'b0;
            done_o  <= 1'b0;
            sum_o   <= '0;
            cout_o  <= 1'b0;
            ovf_o   <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        a_q     <= a_i;
                        b_q     <= sub_i ? ~b_i : b_i;
                        carry_q <= sub_i | cin_i;
                        cnt_q   <= '0;
                        busy_o  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    a_q     <= a_q >> 1;
                    b_q     <= b_q >> 1;
                    carry_q <= carry_d;
                    res_q   <= res_d;
                    cnt_q   <= cnt_q + CW'(1);
                    // At the MSB step carry_q still holds the carry into the MSB.
                    if (last_bit) begin
                        sum_o   <= res_d;
                        cout_o  <= carry_d;
                        ovf_o   <= carry_q ^ carry_d;
                        done_o  <= 1'b1;
                        busy_o  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: WIDTH=8 and WIDTH=1 instances, expected
// results from a plain-arithmetic model, checked by per-instance monitors.
module tb_serial_adder;

    typedef struct {
        logic [7:0] sum;
        logic       c;
        logic       o;
        int         t;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    logic       start8, sub8, cin8, busy8, done8, cout8, ovf8;
    logic [7:0] a8, b8, sum8;
    logic       start1, sub1, cin1, busy1, done1, cout1, ovf1;
    logic [0:0] a1, b1, sum1;

    exp_t q8[$];
    exp_t q1[$];

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start_i(start8), .sub_i(sub8), .a_i(a8), .b_i(b8),
        .cin_i(cin8), .busy_o(busy8), .done_o(done8), .sum_o(sum8), .cout_o(cout8),
        .ovf_o(ovf8)
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .start_i(start1), .sub_i(sub1), .a_i(a1), .b_i(b1),
        .cin_i(cin1), .busy_o(busy1), .done_o(done1), .sum_o(sum1), .cout_o(cout1),
        .ovf_o(ovf1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: sum/cout from unsigned arithmetic, ovf from signed range.
    function automatic exp_t model(input int w, input bit s, input longint a,
                                   input longint b, input bit ci);
        longint m;
        longint r;
        longint sa;
        longint sb;
        exp_t   e;
        m  = 64'sd1 <<< w;
        sa = (a >= m / 2) ? a - m : a;
        sb = (b >= m / 2) ? b - m : b;
        e.t = 0;
        if (!s) begin
            r     = a + b + longint'(ci);
            e.sum = 8'(r % m);
            e.c   = (r >= m);
            r     = sa + sb + longint'(ci);
        end else begin
            r     = a - b;
            e.sum = 8'((r + m) % m);
            e.c   = (a >= b);
            r     = sa - sb;
        end
        e.o = (r >= m / 2) || (r < -(m / 2));
        return e;
    endfunction

    // Monitors: pop on done, otherwise the held outputs must not move.
    logic [7:0] last8_sum;
    logic       last8_c, last8_o;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            last8_sum = '0; last8_c = 1'b0; last8_o = 1'b0;
        end else if (done8) begin
            if (q8.size() == 0) begin
                chk("w8_unexpected_done", 1, 0);
            end else begin
                e = q8.pop_front();
                chk("w8_sum", sum8, e.sum);
                chk("w8_cout", cout8, e.c);
                chk("w8_ovf", ovf8, e.o);
                chk("w8_latency", cyc - e.t, 8);
                chk("w8_busy_at_done", busy8, 0);
                $display("w8 done: sum=%02h cout=%0b ovf=%0b", sum8, cout8, ovf8);
                last8_sum = e.sum; last8_c = e.c; last8_o = e.o;
            end
        end else begin
            chk("w8_hold", {cout8, ovf8, sum8}, {last8_c, last8_o, last8_sum});
        end
    end

    logic [7:0] last1_sum;
    logic       last1_c, last1_o;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            last1_sum = '0; last1_c = 1'b0; last1_o = 1'b0;
        end else if (done1) begin
            if (q1.size() == 0) begin
                chk("w1_unexpected_done", 1, 0);
            end else begin
                e = q1.pop_front();
                chk("w1_cout_sum", {cout1, sum1}, {e.c, e.sum[0]});
                chk("w1_ovf", ovf1, e.o);
                chk("w1_latency", cyc - e.t, 1);
                $display("w1 done: {cout,sum}=%0d ovf=%0b", {cout1, sum1}, ovf1);
                last1_sum = e.sum; last1_c = e.c; last1_o = e.o;
            end
        end else begin
            chk("w1_hold", {cout1, ovf1, sum1}, {last1_c, last1_o, last1_sum[0]});
        end
    end

    // All driver tasks start and end at posedge+#1.
    task automatic issue8(input bit s, input logic [7:0] a, input logic [7:0] b, input bit ci);
        exp_t e;
        int   g = 0;
        while (busy8 && g < 50) begin
            @(posedge clk); #1; g++;
        end
        if (g >= 50) chk("w8_idle_timeout", 0, 1);
        start8 = 1'b1; sub8 = s; a8 = a; b8 = b; cin8 = ci;
        @(posedge clk); #1;
        start8 = 1'b0;
        e = model(8, s, a, b, ci);
        e.t = cyc;
        q8.push_back(e);
    endtask

    task automatic issue1(input bit s, input bit a, input bit b, input bit ci);
        exp_t e;
        int   g = 0;
        while (busy1 && g < 50) begin
            @(posedge clk); #1; g++;
        end
        if (g >= 50) chk("w1_idle_timeout", 0, 1);
        start1 = 1'b1; sub1 = s; a1 = a; b1 = b; cin1 = ci;
        @(posedge clk); #1;
        start1 = 1'b0;
        e = model(1, s, longint'(a), longint'(b), ci);
        e.t = cyc;
        q1.push_back(e);
    endtask

    task automatic wait_done8();
        int g = 0;
        while (!done8 && g < 50) begin
            @(posedge clk); #1; g++;
        end
        if (!done8) chk("w8_done_timeout", 0, 1);
    endtask

    task automatic wait_done1();
        int g = 0;
        while (!done1 && g < 50) begin
            @(posedge clk); #1; g++;
        end
        if (!done1) chk("w1_done_timeout", 0, 1);
    endtask

    initial begin
        int d1;
        rst = 1'b1;
        start8 = 0; sub8 = 0; cin8 = 0; a8 = '0; b8 = '0;
        start1 = 0; sub1 = 0; cin1 = 0; a1 = '0; b1 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", busy8, 0);
        chk("reset_done", done8, 0);
        chk("reset_out", {cout8, ovf8, sum8}, 0);
        chk("reset_w1_out", {busy1, done1, cout1, ovf1, sum1}, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed vectors
        issue8(0, 8'h5A, 8'hA5, 1); wait_done8();
        issue8(0, 8'h7F, 8'h01, 0); wait_done8();
        issue8(1, 8'h10, 8'h20, 0); wait_done8();
        issue8(1, 8'h80, 8'h01, 0); wait_done8();
        @(posedge clk); #1;

        // start held during RUN with other operands is ignored
        issue8(0, 8'h12, 8'h34, 1);
        start8 = 1'b1; sub8 = 1'b1; a8 = 8'hFF; b8 = 8'hEE; cin8 = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        chk("busy_mid_run", busy8, 1);
        start8 = 1'b0;
        wait_done8();
        repeat (4) begin @(posedge clk); #1; end

        // Reset in cycle 4 of RUN aborts and clears outputs immediately
        issue8(0, 8'h21, 8'h11, 0);
        repeat (3) begin @(posedge clk); #1; end
        #2 rst = 1'b1;
        #1;
        chk("abort_out", {cout8, ovf8, sum8}, 0);
        chk("abort_busy_done", {busy8, done8}, 0);
        q8.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (12) begin @(posedge clk); #1; end
        issue8(0, 8'h03, 8'h04, 0); wait_done8();
        @(posedge clk); #1;

        // Back-to-back: second start in the done cycle
        issue8(0, 8'h40, 8'h02, 0); wait_done8();
        d1 = cyc;
        issue8(0, 8'hFF, 8'h01, 0); wait_done8();
        chk("b2b_gap", cyc - d1, 9);
        @(posedge clk); #1;

        // Randomized operations
        for (int i = 0; i < 40; i++) begin
            issue8(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
                   1'($urandom_range(0, 1)));
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
            end
        end
        wait_done8();
        @(posedge clk); #1;

        // WIDTH=1 exhaustive add, plus a few subtracts
        for (int k = 0; k < 8; k++) begin
            issue1(0, k[2], k[1], k[0]);
            wait_done1();
        end
        for (int k = 0; k < 4; k++) begin
            issue1(1, k[1], k[0], 0);
            wait_done1();
        end

        repeat (12) begin @(posedge clk); #1; end
        chk("w8_queue_empty", q8.size(), 0);
        chk("w1_queue_empty", q1.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
